// File: rtl/boot_ctrl_pkg.sv
// Shared boot-sequencer definitions: state encoding visible to debug/status
// decode logic, plus small helpers for decoding the state register.
package boot_ctrl_pkg;

    localparam logic [2:0] BC_IDLE = 3'd0;
    localparam logic [2:0] BC_LOAD = 3'd1;
    localparam logic [2:0] BC_HOLD = 3'd2;
    localparam logic [2:0] BC_RUN  = 3'd3;
    localparam logic [2:0] BC_ERR  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = BC_IDLE,
        ST_LOAD = BC_LOAD,
        ST_HOLD = BC_HOLD,
        ST_RUN  = BC_RUN,
        ST_ERR  = BC_ERR
    } bc_state_e;

    function automatic logic bc_is_busy(input bc_state_e s);
        return (s == ST_LOAD) || (s == ST_HOLD);
    endfunction

    // start is honoured only where no session is in flight
    function automatic logic bc_accepts_start(input bc_state_e s);
        return (s == ST_IDLE) || (s == ST_RUN) || (s == ST_ERR);
    endfunction

endpackage

// File: rtl/boot_ctrl.sv
// Boot sequencer: holds the core in reset, streams a program image into
// instruction memory from word 0, then releases reset after a settle delay.
module boot_ctrl
    import boot_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int MAX_WORDS   = 256,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [31:0]           s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] MAX_LAST  = (ADDR_WIDTH+1)'(MAX_WORDS - 1);
    localparam logic [CW-1:0]       HOLD_ONE  = CW'(1);
    localparam logic [CW-1:0]       HOLD_LAST = CW'(HOLD_CYCLES - 1);

    bc_state_e             state_q, state_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic [CW-1:0]         hold_cnt_q, hold_cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  accept;

    // The write address is the count of beats already accepted this session;
    // MAX_WORDS <= 2**ADDR_WIDTH keeps the low bits from ever wrapping.
    assign accept = s_valid && (state_q == ST_LOAD);

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        hold_cnt_d   = hold_cnt_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;

        unique case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start && bc_accepts_start(state_q)) begin
                    state_d      = ST_LOAD;
                    word_count_d = '0;
                    hold_cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    we_d         = 1'b1;
                    waddr_d      = word_count_q[ADDR_WIDTH-1:0];
                    wdata_d      = s_data;
                    word_count_d = word_count_q + CNT_ONE;
                    // s_last wins: a final beat that exactly fills the image is legal
                    if (s_last) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = '0;
                    end else if (word_count_q == MAX_LAST) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            word_count_q <= '0;
            hold_cnt_q   <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            hold_cnt_q   <= hold_cnt_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign s_ready    = (state_q == ST_LOAD);
    assign core_reset = (state_q != ST_RUN);
    assign busy       = bc_is_busy(state_q);
    assign done       = (state_q == ST_RUN);
    assign error      = (state_q == ST_ERR);
    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_boot_ctrl.sv
// Randomized self-checking bench for boot_ctrl against a word-list model.
module tb_boot_ctrl;

    localparam int AW = 3;
    localparam int MW = 6;
    localparam int HC = 4;

    logic          clk = 1'b0;
    logic          reset, start, s_valid, s_last;
    logic [31:0]   s_data;
    logic          s_ready, imem_we, core_reset, busy, done, error;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;

    boot_ctrl #(.ADDR_WIDTH(AW), .MAX_WORDS(MW), .HOLD_CYCLES(HC)) dut (
        .clk(clk), .reset(reset), .start(start),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .core_reset(core_reset), .busy(busy), .done(done), .error(error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    logic [31:0] exp_mem [0:(1<<AW)-1];

    // Behaves like the instruction memory: captures each write at the clock edge.
    logic [31:0]   mem [0:(1<<AW)-1];
    logic          prev_we = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    int            dup_cnt = 0;
    always @(posedge clk) begin
        if (imem_we) begin
            mem[imem_waddr] = imem_wdata;
            if (prev_we && prev_addr == imem_waddr) dup_cnt++;
        end
        prev_we   = imem_we;
        prev_addr = imem_waddr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_cnt = 0;
        checks++;
        if ({s_ready, core_reset, busy, done, error} !== 5'b11100) begin
            errors++;
            $display("FAIL start_state: got rdy/crst/busy/done/err=%b want 11100",
                     {s_ready, core_reset, busy, done, error});
        end
        checks++;
        if (word_count !== '0) begin
            errors++;
            $display("FAIL start_count: got %0d want 0", word_count);
        end
    endtask

    // One beat, preceded by `gap` idle cycles; optionally pulses start alongside.
    task automatic send_beat(input logic [31:0] data, input logic last,
                             input int gap, input bit ign_start);
        for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            s_data  = $urandom;
            s_last  = 1'($urandom % 2);
            start   = ign_start ? 1'($urandom % 2) : 1'b0;
            tick();
            start = 1'b0;
            checks++;
            if (imem_we !== 1'b0 || word_count !== (AW+1)'(exp_cnt)) begin
                errors++;
                $display("FAIL idle_cycle: got we=%b cnt=%0d want we=0 cnt=%0d",
                         imem_we, word_count, exp_cnt);
            end
        end
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        start   = ign_start ? 1'($urandom % 2) : 1'b0;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_in_load: got %b want 1", s_ready);
        end
        tick();
        s_valid = 1'b0;
        start   = 1'b0;
        if (exp_cnt < MW) exp_mem[exp_cnt] = data;
        checks++;
        if (imem_we !== 1'b1 || imem_waddr !== AW'(exp_cnt) || imem_wdata !== data) begin
            errors++;
            $display("FAIL write_port: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                     imem_we, imem_waddr, imem_wdata, exp_cnt, data);
        end
        exp_cnt++;
        checks++;
        if (word_count !== (AW+1)'(exp_cnt)) begin
            errors++;
            $display("FAIL word_count: got %0d want %0d", word_count, exp_cnt);
        end
    endtask

    task automatic check_mem(input int n);
        for (int a = 0; a < n; a++) begin
            checks++;
            if (mem[a] !== exp_mem[a]) begin
                errors++;
                $display("FAIL mem_contents[%0d]: got %h want %h", a, mem[a], exp_mem[a]);
            end
        end
    endtask

    // Last beat already accepted; counts cycles until core reset releases.
    task automatic expect_run(input int n, input bit ign_start);
        int k = 0;
        checks++;
        if ({busy, s_ready, core_reset, done} !== 4'b1010) begin
            errors++;
            $display("FAIL hold_entry: got busy/rdy/crst/done=%b want 1010",
                     {busy, s_ready, core_reset, done});
        end
        while (core_reset === 1'b1 && k < 50) begin
            start = ign_start ? 1'($urandom % 2) : 1'b0;
            tick();
            start = 1'b0;
            k++;
        end
        checks++;
        if (k !== HC) begin
            errors++;
            $display("FAIL hold_cycles: got %0d want %0d", k, HC);
        end
        checks++;
        if ({done, busy, error, core_reset} !== 4'b1000 || word_count !== (AW+1)'(n)) begin
            errors++;
            $display("FAIL run_state: got done/busy/err/crst=%b cnt=%0d want 1000 cnt=%0d",
                     {done, busy, error, core_reset}, word_count, n);
        end
        check_mem(n);
    endtask

    task automatic run_image(input int n, input int gap_mode, input bit ign_start);
        int gap;
        do_start();
        for (int i = 0; i < n; i++) begin
            gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : $urandom_range(0, 2);
            send_beat($urandom, (i == n - 1), gap, ign_start);
        end
        expect_run(n, ign_start);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if ({core_reset, s_ready, imem_we, busy, done, error} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 100000",
                     {core_reset, s_ready, imem_we, busy, done, error});
        end
        checks++;
        if (imem_waddr !== '0 || imem_wdata !== '0 || word_count !== '0) begin
            errors++;
            $display("FAIL reset_regs: got addr=%0d data=%h cnt=%0d want 0",
                     imem_waddr, imem_wdata, word_count);
        end
    endtask

    task automatic test_normal_load();
        logic [31:0] img [4] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000063};
        do_start();
        for (int i = 0; i < 4; i++) send_beat(img[i], (i == 3), 0, 1'b0);
        expect_run(4, 1'b0);
    endtask

    task automatic test_gapped_valid();
        run_image(MW, 1, 1'b0);
    endtask

    task automatic test_reload_from_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_cnt = 0;
        checks++;
        if (core_reset !== 1'b1 || word_count !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reload: got crst=%b cnt=%0d done=%b want 1 0 0",
                     core_reset, word_count, done);
        end
        for (int i = 0; i < 3; i++) send_beat($urandom, (i == 2), 0, 1'b0);
        expect_run(3, 1'b0);
    endtask

    task automatic test_overflow();
        int wrote;
        do_start();
        for (int i = 0; i < MW; i++) send_beat($urandom, 1'b0, $urandom_range(0, 1), 1'b0);
        checks++;
        if ({error, core_reset, s_ready, busy, done} !== 5'b11000 || word_count !== (AW+1)'(MW)) begin
            errors++;
            $display("FAIL overflow_err: got err/crst/rdy/busy/done=%b cnt=%0d want 11000 cnt=%0d",
                     {error, core_reset, s_ready, busy, done}, word_count, MW);
        end
        wrote = 0;
        s_valid = 1'b1; s_data = $urandom; s_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (imem_we === 1'b1) wrote++;
        end
        s_valid = 1'b0;
        checks++;
        if (wrote !== 0 || error !== 1'b1 || word_count !== (AW+1)'(MW)) begin
            errors++;
            $display("FAIL err_sticky: got writes=%0d err=%b cnt=%0d want 0 1 %0d",
                     wrote, error, word_count, MW);
        end
        check_mem(MW);
        run_image(2, 0, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        do_start();
        send_beat($urandom, 1'b0, 0, 1'b0);
        send_beat($urandom, 1'b0, 0, 1'b0);
        s_valid = 1'b1; s_data = 32'hDEADBEEF; s_last = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; s_valid = 1'b0;
        checks++;
        if ({imem_we, busy, core_reset, s_ready, done, error} !== 6'b001000 || word_count !== '0) begin
            errors++;
            $display("FAIL reset_mid_load: got we/busy/crst/rdy/done/err=%b cnt=%0d want 001000 cnt=0",
                     {imem_we, busy, core_reset, s_ready, done, error}, word_count);
        end
        check_mem(2);
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_accept: got we=%b rdy=%b want 0 0", imem_we, s_ready);
        end
        exp_cnt = 0;
    endtask

    task automatic test_ignored_start();
        run_image(5, 2, 1'b1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++)
            run_image($urandom_range(1, MW), $urandom_range(0, 2), 1'($urandom % 2));
    endtask

    task automatic test_no_dup();
        checks++;
        if (dup_cnt !== 0) begin
            errors++;
            $display("FAIL duplicate_write: got %0d repeated-address writes want 0", dup_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_normal_load();
        test_gapped_valid();
        test_reload_from_run();
        test_overflow();
        test_reset_mid_load();
        test_ignored_start();
        test_random();
        test_no_dup();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/boot_ctrl.md
# boot_ctrl

Boot sequencer for the single-cycle RV32 core. It holds the core in reset, accepts a program image as a stream of 32-bit words over a valid/ready handshake, and writes that image into instruction memory from word address 0 upward. After a fixed settle delay it releases the core's reset. It sits between the SoC-level reset/loader link and the core's `reset` input and instruction-memory write port.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: instruction-memory word-address width.
- `MAX_WORDS`, default 256: image capacity in words; must satisfy 1 ≤ MAX_WORDS ≤ 2**ADDR_WIDTH.
- `HOLD_CYCLES`, default 4: cycles that core reset stays asserted after the final beat; must be ≥ 1.

Ports:
- `clk` input, 1: single clock.
- `reset` input, 1: synchronous, active-high.
- `start` input, 1: single-cycle pulse that begins a load session.
- `s_valid` input, 1: image beat valid.
- `s_data` input, 32: image word.
- `s_last` input, 1: marks the final image word.
- `s_ready` output, 1: block accepts a beat.
- `imem_we` output, 1: instruction-memory write enable.
- `imem_waddr` output, ADDR_WIDTH: word address of the write.
- `imem_wdata` output, 32: write data.
- `core_reset` output, 1: drives the core's `reset`.
- `busy` output, 1: high in LOAD or HOLD.
- `done` output, 1: high in RUN.
- `error` output, 1: high in ERR.
- `word_count` output, ADDR_WIDTH+1: beats accepted in the current or last session.

## Operation
- States are IDLE, LOAD, HOLD, RUN and ERR.
- Reset values:
  - state = IDLE
  - core_reset = 1
  - s_ready = 0, imem_we = 0, imem_waddr = 0, imem_wdata = 0
  - word_count = 0
  - busy = done = error = 0
- **IDLE**: core_reset = 1. `start` moves to LOAD and clears the address and word_count.
- **LOAD**:
  - s_ready = 1 and core_reset = 1.
  - Beat accepted when s_valid && s_ready. The accepted word is written at the current address, then the address and word_count increment.
  - An accepted beat with s_last = 1 moves to HOLD.
  - If the accepted beat is number MAX_WORDS (word_count becomes MAX_WORDS) and s_last = 0, move to ERR. Beats already written are kept.
- **HOLD**:
  - s_ready = 0 and core_reset = 1.
  - Hold counter counts HOLD_CYCLES cycles, then moves to RUN.
- **RUN**: core_reset = 0 and done = 1. `start` moves to LOAD (reload); core_reset reasserts with LOAD.
- **ERR**: core_reset = 1 and error = 1. `start` moves to LOAD (retry), clearing error, the address and word_count. Only `start` or `reset` exits ERR.
- `start` is ignored in LOAD and HOLD.
- word_count holds its final value through HOLD, RUN and ERR until the next `start`.
- Every status output (busy, done, error) is decoded from the state register only.

## Timing
- s_ready is a function of the state register only; there is no combinational path from s_valid, s_data or s_last to any output.
- Write latency is 1 cycle:
  - Beat accepted at edge E.
  - imem_we = 1 with the registered imem_waddr/imem_wdata during cycle E+1.
  - The memory captures the write at edge E+1.
- Back-to-back beats give one write per cycle; imem_we is never high for two cycles with the same address.
- Last beat accepted at edge E:
  - State is HOLD from E through E+HOLD_CYCLES−1; the final write occurs in the first HOLD cycle.
  - RUN starts, and core_reset falls, at edge E+HOLD_CYCLES.
- `start` seen at edge S (from IDLE, RUN or ERR): s_ready = 1 from edge S.
- `reset` mid-session: at the next edge all registers take their reset values. A write registered in the same edge is dropped (imem_we = 0), and core_reset stays 1.
- Address wrap cannot occur because MAX_WORDS ≤ 2**ADDR_WIDTH.

## Structure
- State encoding (3-bit localparams `BC_IDLE`…`BC_ERR`) lives in the shared processor definitions package/header, so the debug/status logic can decode it.
- A single module with no sub-module. The hold counter and write register are inline, sized `$clog2(HOLD_CYCLES+1)` bits.

## Test plan
- **Normal load**: reset, then `start`. Stream 4 words 0x00500093, 0x00A00113, 0x002081B3, 0x00000063 with s_last on word 4 → writes at addresses 0–3 with matching data, word_count = 4, core_reset falls exactly HOLD_CYCLES = 4 cycles after the last acceptance, done = 1.
- **Gapped valid**: toggle s_valid 1/0 every cycle for 6 words → 6 writes at consecutive addresses with no duplicates, and the address is unchanged on idle cycles.
- **Overflow** (MAX_WORDS = 4): send 4 beats without s_last → ERR, error = 1, core_reset = 1, word_count = 4, s_ready = 0. A following `start` then a 2-word load → RUN with word_count = 2.
- **Reload from RUN**: `start` in RUN → core_reset = 1 at the next edge, word_count = 0, new image written from address 0.
- **Reset mid-load**: assert reset in the cycle a beat is accepted → next cycle imem_we = 0, state IDLE, core_reset = 1, word_count = 0.
- **Ignored start**: `start` pulses during LOAD and HOLD → no address or count reset, and the RUN timing is unchanged.
